seg7_bcd_driver: RTL
====================

SEG7_BCD_DRIVER -- requirements
Module: seg7_bcd_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per display digit slot; legal range 2 to 2^20.
REQ-002 Parameter BLANK_LZ, default 1: 1 blanks leading zeros; 0 shows all three digits.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port wr_en  input  1  one-cycle write strobe from the I/O block's 7-segment register write.
REQ-006 Port wr_data  input  8  unsigned binary value to display, sampled when wr_en=1.
REQ-007 Port busy  output  1  high while a conversion is in progress.
REQ-008 Port done  output  1  one-cycle pulse when a conversion result is committed.
REQ-009 Port bcd  output  12  committed result: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-010 Port seg  output  7  segment drive for the selected digit, active-low, bit order gfedcba.
REQ-011 Port an  output  3  digit select, active-low one-hot: [0] units, [1] tens, [2] hundreds.

Function
REQ-012 The block SHALL convert binary to BCD with a sequential shift-add-3 FSM that has three states: IDLE, CONV and COMMIT.
REQ-013 In IDLE with a start request, the block SHALL load the source value into an 8-bit shift register, clear the 12-bit BCD scratch, clear the iteration count, and enter CONV.
REQ-014 In CONV, each cycle SHALL add 3 to every scratch nibble that is 5 or more, then shift {scratch, shift register} left by 1, then increment the count.
REQ-015 After the 8th CONV cycle, the FSM SHALL enter COMMIT.
REQ-016 In COMMIT, the block SHALL copy the scratch to bcd, pulse done high for exactly that cycle, and return to IDLE.
REQ-017 Latency: for wr_en sampled at edge N in IDLE, done SHALL be high during the cycle after edge N+9, and bcd SHALL be valid from that same cycle.
REQ-018 busy SHALL be high in CONV and COMMIT and low in IDLE.
REQ-019 The pending buffer is one entry deep; wr_en while busy=1 (COMMIT cycle included) SHALL store wr_data there.
REQ-020 A second write while the pending buffer is already valid SHALL overwrite it (latest value wins); no error is flagged.
REQ-021 A start request in IDLE SHALL come from wr_en or from a valid pending entry; wr_en has priority, and its value supersedes and clears the pending entry.
REQ-022 If pending is valid on the COMMIT-to-IDLE transition, the FSM SHALL start that conversion on the next edge, so there is exactly 1 IDLE cycle between conversions.
REQ-023 bcd SHALL hold its value between commits; the display SHALL always show the committed bcd, never the scratch.
REQ-024 The prescaler SHALL count from 0 to SCAN_DIV-1 and wrap, producing a scan tick on the wrap.
REQ-025 On each scan tick, the digit index SHALL advance units -> tens -> hundreds -> units.
REQ-026 an SHALL be 3'b110 for units, 3'b101 for tens and 3'b011 for hundreds, and SHALL change only on a scan tick.
REQ-027 Segment encoding for digits 0-9 SHALL be 40,79,24,30,19,12,02,78,00,10 (hex); the blank pattern is 7F.
REQ-028 Any nibble value above 9 SHALL display the blank pattern 7F.
REQ-029 With BLANK_LZ=1, hundreds SHALL be blank when it is 0, tens SHALL be blank when both hundreds and tens are 0, and units SHALL never be blanked.
REQ-030 seg and an SHALL be registered outputs that update together in the same cycle.

Reset
REQ-031 While rst=1, the FSM SHALL be in IDLE, pending SHALL be cleared, and busy=0, done=0, bcd=12'h000.
REQ-032 While rst=1, prescaler=0, the digit index SHALL be units, an=3'b110 and seg=7'h40.
REQ-033 Reset during CONV or COMMIT SHALL abort the conversion with no done pulse; bcd SHALL read 0.
REQ-034 After rst is released, the first clock edge SHALL resume normal operation with no further latency.

Verification
REQ-035 Write 8'd255 in IDLE -> busy high for 9 cycles, one done pulse, bcd=12'h255.
REQ-036 Write 8'd7 with BLANK_LZ=1 and SCAN_DIV=4 -> units seg=78, tens seg=7F, hundreds seg=7F; an steps 110,101,011 every 4 cycles.
REQ-037 Write 100, then write 42 and then 9 during busy -> done pulses with bcd=12'h100 then 12'h009; 42 is never committed.
REQ-038 Write 8'd0 with BLANK_LZ=0 -> bcd=12'h000; all three digits show seg=40.
REQ-039 Assert rst in the 4th CONV cycle after writing 200 -> no done pulse, bcd=0, an=3'b110, seg=40; a write of 5 after release gives bcd=12'h005.
REQ-040 Write coincident with the COMMIT cycle of the value 64 -> bcd=12'h064 first, then exactly 1 IDLE cycle, then the new conversion starts.

Source files
------------

// File: rtl/seg7_bcd_driver.sv
// Binary-to-BCD converter (sequential shift-add-3) feeding a three-digit
// multiplexed 7-segment display with optional leading-zero blanking.
module seg7_bcd_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic            LZ_EN     = (BLANK_LZ != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t        r_state;
    logic [7:0]    r_shift;
    logic [11:0]   r_scratch;
    logic [3:0]    r_count;
    logic          r_pend_vld;
    logic [7:0]    r_pend_data;
    logic          r_busy;
    logic          r_done;
    logic [11:0]   r_bcd;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [6:0]    r_seg;
    logic [2:0]    r_an;

    logic [11:0]   w_adj;
    logic [11:0]   w_scratch_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_tick;
    logic [1:0]    w_idx_nxt;
    logic          w_blank_h;
    logic          w_blank_t;
    logic [6:0]    w_seg_nxt;
    logic [2:0]    w_an_nxt;

    function automatic logic [3:0] add3(input logic [3:0] n);
        if (n >= 4'd5) begin
            return n + 4'd3;
        end else begin
            return n;
        end
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // One shift-add-3 iteration: correct every nibble, then shift the joint register left
    always_comb begin
        w_adj         = {add3(r_scratch[11:8]), add3(r_scratch[7:4]), add3(r_scratch[3:0])};
        w_scratch_nxt = {w_adj[10:0], r_shift[7]};
        w_shift_nxt   = {r_shift[6:0], 1'b0};
    end

    // Conversion FSM with one-deep pending buffer and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= 8'd0;
            r_scratch   <= 12'd0;
            r_count     <= 4'd0;
            r_pend_vld  <= 1'b0;
            r_pend_data <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bcd       <= 12'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wr_en) begin
                        r_shift    <= wr_data;
                        r_scratch  <= 12'd0;
                        r_count    <= 4'd0;
                        r_pend_vld <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CONV;
                    end else if (r_pend_vld) begin
                        r_shift    <= r_pend_data;
                        r_scratch  <= 12'd0;
                        r_count    <= 4'd0;
                        r_pend_vld <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CONV;
                    end else begin
                        r_busy     <= 1'b0;
                    end
                end
                ST_CONV: begin
                    r_scratch <= w_scratch_nxt;
                    r_shift   <= w_shift_nxt;
                    r_count   <= r_count + 4'd1;
                    r_busy    <= 1'b1;
                    if (r_count == 4'd7) begin
                        r_state <= ST_COMMIT;
                    end
                    if (wr_en) begin
                        r_pend_vld  <= 1'b1;
                        r_pend_data <= wr_data;
                    end
                end
                ST_COMMIT: begin
                    r_bcd   <= r_scratch;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (wr_en) begin
                        r_pend_vld  <= 1'b1;
                        r_pend_data <= wr_data;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Next digit slot and its segment pattern, always taken from the committed result
    always_comb begin
        w_tick = (r_presc == PRESC_MAX);
        if (w_tick) begin
            if (r_idx == 2'd2) begin
                w_idx_nxt = 2'd0;
            end else begin
                w_idx_nxt = r_idx + 2'd1;
            end
        end else begin
            w_idx_nxt = r_idx;
        end
        w_blank_h = LZ_EN && (r_bcd[11:8] == 4'd0);
        w_blank_t = w_blank_h && (r_bcd[7:4] == 4'd0);
        case (w_idx_nxt)
            2'd0: begin
                w_an_nxt  = 3'b110;
                w_seg_nxt = seg_enc(r_bcd[3:0]);
            end
            2'd1: begin
                w_an_nxt = 3'b101;
                if (w_blank_t) begin
                    w_seg_nxt = 7'h7F;
                end else begin
                    w_seg_nxt = seg_enc(r_bcd[7:4]);
                end
            end
            2'd2: begin
                w_an_nxt = 3'b011;
                if (w_blank_h) begin
                    w_seg_nxt = 7'h7F;
                end else begin
                    w_seg_nxt = seg_enc(r_bcd[11:8]);
                end
            end
            default: begin
                w_an_nxt  = 3'b110;
                w_seg_nxt = 7'h7F;
            end
        endcase
    end

    // Scan prescaler, digit index and registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_an    <= 3'b110;
            r_seg   <= 7'h40;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_idx <= w_idx_nxt;
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule
